// File: rtl/pulse_stretch4bit.sv
// Four independent strobe-to-pulse stretchers with per-channel strobe queues.
// Each channel emits fixed-width pulses separated by a guaranteed low gap.
module pulse_stretch4bit #(
  parameter int unsigned PULSE_CYCLES = 5_000_000,
  parameter int unsigned GAP_CYCLES   = 5_000_000,
  parameter int unsigned MAX_PENDING  = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] trigger,
  input  logic [3:0] clr_overflow,
  output logic [3:0] pulse,
  output logic [3:0] busy,
  output logic [3:0] overflow,
  output logic [7:0] dbg_state
);

  localparam int unsigned MAX_CYC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MAX_CYC + 1);
  localparam int PW = $clog2(MAX_PENDING + 1);

  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PEND_MAX   = PW'(MAX_PENDING);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [PW-1:0] PEND_ONE   = PW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  for (genvar g = 0; g < 4; g++) begin : g_ch
    state_e          r_state;
    state_e          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [PW-1:0]   r_pend;
    logic [PW-1:0]   w_pend_nxt;
    logic            r_ovf;
    logic            w_ovf_nxt;
    logic            r_pulse;
    logic            r_busy;
    logic            w_cnt_zero;
    logic            w_queue;
    logic            w_drop;

    assign w_cnt_zero = (r_cnt == '0);

    // Strobes that cannot start a pulse right away go to the pending queue;
    // the gap-end cycle is excluded because it hands the strobe over directly.
    assign w_queue = trigger[g] &&
                     ((r_state == S_HIGH) || ((r_state == S_GAP) && !w_cnt_zero));

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_pend_nxt  = r_pend;
      w_drop      = 1'b0;

      case (r_state)
        S_IDLE: begin
          if (trigger[g]) begin
            w_state_nxt = S_HIGH;
            w_cnt_nxt   = PULSE_LOAD;
          end
        end
        S_HIGH: begin
          if (w_cnt_zero) begin
            w_state_nxt = S_GAP;
            w_cnt_nxt   = GAP_LOAD;
          end else begin
            w_cnt_nxt = r_cnt - CNT_ONE;
          end
        end
        S_GAP: begin
          if (!w_cnt_zero) begin
            w_cnt_nxt = r_cnt - CNT_ONE;
          end else if (r_pend != '0) begin
            // A same-cycle strobe replaces the one taken off the queue.
            w_state_nxt = S_HIGH;
            w_cnt_nxt   = PULSE_LOAD;
            if (!trigger[g]) begin
              w_pend_nxt = r_pend - PEND_ONE;
            end
          end else if (trigger[g]) begin
            w_state_nxt = S_HIGH;
            w_cnt_nxt   = PULSE_LOAD;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase

      if (w_queue) begin
        if (r_pend == PEND_MAX) begin
          w_drop = 1'b1;
        end else begin
          w_pend_nxt = r_pend + PEND_ONE;
        end
      end

      w_ovf_nxt = w_drop | (r_ovf & ~clr_overflow[g]);
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_pend  <= '0;
        r_ovf   <= 1'b0;
        r_pulse <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_pend  <= w_pend_nxt;
        r_ovf   <= w_ovf_nxt;
        r_pulse <= (w_state_nxt == S_HIGH);
        r_busy  <= (w_state_nxt != S_IDLE) || (w_pend_nxt != '0);
      end
    end

    assign pulse[g]           = r_pulse;
    assign busy[g]            = r_busy;
    assign overflow[g]        = r_ovf;
    assign dbg_state[2*g +: 2] = r_state;
  end

endmodule

// File: doc/pulse_stretch4bit.md
# pulse_stretch4bit

Four-channel output pulse generator for the vending machine: the output-side counterpart of the debounced button inputs. The controller FSM raises single-cycle event strobes (dispense, coin-return, change, error beep). This block converts each strobe into one clean, fixed-width pulse with a guaranteed low gap, so downstream solenoids, LEDs and buzzers see well-formed pulses. Strobes arriving while a channel is busy are queued per channel, up to a fixed depth, rather than lost.

## Interface
- PULSE_CYCLES, 5_000_000: high time of each output pulse, in clk cycles (100 ms at 50 MHz); must be ≥1.
- GAP_CYCLES, 5_000_000: minimum low time after each pulse before the next may start; must be ≥1.
- MAX_PENDING, 7: per-channel queue depth (count of waiting strobes); must be ≥1.
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-low reset.
- trigger  input  4  per-channel single-cycle event strobe; a high level is counted once per cycle.
- clr_overflow  input  4  per-channel clear of the sticky overflow flag.
- pulse  output  4  registered stretched pulse output.
- busy  output  4  registered; high while a channel is pulsing, in its gap, or has queued strobes.
- overflow  output  4  registered sticky flag; set when a strobe is dropped.

## Operation
- Channels are four identical, fully independent instances of the same per-channel logic.
- Per-channel state: FSM {IDLE, HIGH, GAP}, a down-counter sized to max(PULSE_CYCLES, GAP_CYCLES), and a pending counter of width $clog2(MAX_PENDING+1).
- IDLE: on trigger=1, go to HIGH and load the counter with PULSE_CYCLES−1; the trigger is consumed and pending is unchanged.
- HIGH: pulse=1. Decrement each cycle. At count 0, go to GAP and load GAP_CYCLES−1.
- GAP: pulse=0. Decrement each cycle. At count 0, the channel ends its gap:
  - if pending>0: go to HIGH, pending−1, and a trigger in the same cycle adds +1 (net pending unchanged);
  - else if trigger=1: go to HIGH and consume the trigger;
  - else: go to IDLE.
- A trigger in HIGH or GAP, outside the gap-end cycle, increments pending.
- If pending==MAX_PENDING at that point, the strobe is dropped, pending is unchanged, and overflow is set.
- overflow clears only on reset or on clr_overflow=1. If a set and a clear hit the same cycle, set wins.
- busy = (state≠IDLE) or (pending≠0).
- Reset at any point, including mid-pulse, forces the following on the next edge: state IDLE, pulse 0, pending 0, overflow 0, busy 0.

## Timing
- Reset values: pulse=4'b0000, busy=4'b0000, overflow=4'b0000.
- Latency: a trigger sampled at edge n gives pulse=1 from edge n onward, visible in cycle n+1. This applies when the channel is IDLE, or is at the gap-end cycle with pending==0.
- Pulse width is exactly PULSE_CYCLES cycles.
- Low time between consecutive pulses is exactly GAP_CYCLES cycles when work is queued, and ≥GAP_CYCLES cycles otherwise.
- Queued pulses are back-to-back at period PULSE_CYCLES+GAP_CYCLES. No strobe is merged or lost unless overflow is raised.
- busy rises at the same edge as the first pulse. It falls at the edge that returns the channel to IDLE with pending 0.
- A trigger held high for k cycles counts as k strobes.

## Test plan
All scenarios use PULSE_CYCLES=4, GAP_CYCLES=3, MAX_PENDING=2.
- Reset, then a single trigger[0] strobe at cycle 10 -> pulse[0] high for cycles 11–14, low from 15; busy[0] high for cycles 11–17, low at 18; other channels stay 0.
- trigger[1] at cycles 10, 12, 13 -> three pulses starting at cycles 11, 18 and 25, each 4 cycles wide; pending peaks at 2; overflow[1] stays 0.
- trigger[2] at cycles 10, 11, 12, 13 -> pulses start at cycles 11, 18 and 25 only; overflow[2] goes to 1 at cycle 14 and stays 1 until clr_overflow[2] is pulsed, after which it reads 0 one cycle later.
- trigger[3] exactly at the gap-end cycle (cycle 17, after a strobe at cycle 10) -> the next pulse starts at cycle 18 with no extra idle cycle; pending stays 0.
- All four triggers together at cycle 10, then reset asserted at cycle 12 -> pulse, busy and overflow are all 0 from cycle 13; a new trigger at cycle 15 produces a normal pulse at cycles 16–19.
- Simultaneous overflow set and clr_overflow on one channel -> overflow reads 1.
